envelope_vca: RTL and testbench

//  Voltage-controlled amplifier stage directly downstream of adsr_envelope.

---
 rtl/envelope_vca.sv | 141 ++++++++++++++
 tb/tb_envelope_vca.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/envelope_vca.sv
// Envelope-controlled amplifier: slew-limits the envelope and scales signed samples with a serial shift-add multiplier.
// Latency ENV_W+1 clocks from acceptance to out_valid; one sample in flight, in_ready low until the result is taken.
module envelope_vca #(
    parameter int ENV_W     = 8,
    parameter int SLEW_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] envelope_in,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] env_smooth
);

    localparam int CNT_W = $clog2(ENV_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENV_W);
    localparam logic signed [9:0] STEP_S = 10'(SLEW_STEP);
    localparam logic [7:0] STEP_U = 8'(SLEW_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic             accept;
    logic [CNT_W-1:0] cnt;
    logic signed [9:0] diff;
    logic [7:0]       env_next;
    logic [7:0]       mag;
    logic [15:0]      acc;
    logic [15:0]      mcand;
    logic [7:0]       mplier;
    logic             sign;
    logic             unity;
    logic [7:0]       raw;
    logic [7:0]       r;
    logic [7:0]       result;

    assign accept = in_valid & in_ready;

    // Slew limiter: clamp the per-sample envelope change to SLEW_STEP.
    assign diff = $signed({2'b00, envelope_in}) - $signed({2'b00, env_smooth});

    always_comb begin
        env_next = envelope_in;
        if (SLEW_STEP != 0) begin
            if (diff > STEP_S) begin
                env_next = env_smooth + STEP_U;
            end else if (diff < -STEP_S) begin
                env_next = env_smooth - STEP_U;
            end
        end
    end

    // -128 negates to 0x80, which reads correctly as unsigned 128.
    assign mag = in_data[7] ? (8'd0 - in_data) : in_data;

    // Full scale 0xFF bypasses the product so unity gain is exact.
    assign r      = acc[15:8];
    assign result = unity ? raw : (sign ? (8'd0 - r) : r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MUL;
            MUL:     if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == MUL) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ENV_W shift-add clocks, then a final MUL clock forms the signed result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            sign       <= 1'b0;
            unity      <= 1'b0;
            raw        <= '0;
            env_smooth <= '0;
            out_data   <= '0;
        end else begin
            if (accept) begin
                acc        <= '0;
                mcand      <= {8'd0, mag};
                mplier     <= env_next;
                sign       <= in_data[7];
                unity      <= (env_next == 8'hFF);
                raw        <= in_data;
                env_smooth <= env_next;
            end else if (state == MUL) begin
                if (cnt < CNT_LAST) begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= {mcand[14:0], 1'b0};
                    mplier <= {1'b0, mplier[7:1]};
                end else begin
                    out_data <= result;
                end
            end
        end
    end

endmodule

// File: tb/tb_envelope_vca.sv
// Directed self-checking bench for envelope_vca: reset, gain, slew, unity, backpressure and envelope isolation.
module tb_envelope_vca;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] envelope_in;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] env_smooth;

    int checks = 0;
    int errors = 0;

    envelope_vca #(.ENV_W(8), .SLEW_STEP(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .envelope_in (envelope_in),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .env_smooth  (env_smooth)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one sample, wait (bounded) for the result; transfers it if out_ready is high.
    task automatic run_sample(input logic [7:0] d, output logic [7:0] res, output int lat);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1 lat++;
        end
        res = out_data;
        if (out_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] res;
        int         lat;
        int         bad;
        logic [7:0] held;

        rst         = 1'b1;
        envelope_in = 8'h00;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_data", 32'(out_data), 32'h00);
        check("reset_env_smooth", 32'(env_smooth), 32'h00);
        rst = 1'b0;

        // Half-scale envelope, ramped up from zero over 32 samples.
        envelope_in = 8'h80;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            run_sample(8'h40, res, lat);
            if (lat != 9) bad++;
        end
        check("ramp_latency_all_9", 32'(bad), 32'd0);
        check("half_env_reached", 32'(env_smooth), 32'h80);
        check("half_pos_0x40", 32'(res), 32'h20);
        run_sample(8'h80, res, lat);
        check("half_neg128", 32'(res), 32'hC0);
        run_sample(8'hFF, res, lat);
        check("half_neg1_truncates", 32'(res), 32'h00);
        run_sample(8'h40, res, lat);
        check("half_pos_again", 32'(res), 32'h20);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        in_data  = 8'h7F;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'h00);
        check("midrst_env_smooth", 32'(env_smooth), 32'h00);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        check("midrst_no_stale_valid", 32'(bad), 32'd0);

        // Slew from zero toward full scale, 4 per accepted sample.
        envelope_in = 8'hFF;
        run_sample(8'h7F, res, lat);
        check("slew1_env", 32'(env_smooth), 32'h04);
        check("slew1_out", 32'(res), 32'h01);
        run_sample(8'h7F, res, lat);
        check("slew2_env", 32'(env_smooth), 32'h08);
        check("slew2_out", 32'(res), 32'h03);
        for (int i = 3; i < 64; i++) begin
            run_sample(8'h7F, res, lat);
            if (i == 63) check("slew63_env", 32'(env_smooth), 32'hFC);
        end
        run_sample(8'h7F, res, lat);
        check("slew64_env", 32'(env_smooth), 32'hFF);
        check("slew64_out", 32'(res), 32'h7F);

        // Unity gain is exact.
        run_sample(8'h80, res, lat);
        check("unity_0x80", 32'(res), 32'h80);
        run_sample(8'h7F, res, lat);
        check("unity_0x7F", 32'(res), 32'h7F);
        run_sample(8'h00, res, lat);
        check("unity_0x00", 32'(res), 32'h00);

        // Backpressure: result held, input ignored while out_ready is low.
        out_ready = 1'b0;
        run_sample(8'h40, res, lat);
        check("bp_latency", 32'(lat), 32'd9);
        check("bp_result", 32'(res), 32'h40);
        held        = out_data;
        in_valid    = 1'b1;
        in_data     = 8'h11;
        envelope_in = 8'h00;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || out_data !== held || env_smooth !== 8'hFF) bad++;
        end
        check("bp_stall_stable", 32'(bad), 32'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_after_out_valid", 32'(out_valid), 32'd0);
        check("bp_after_in_ready", 32'(in_ready), 32'd1);
        check("bp_after_out_data_kept", 32'(out_data), 32'h40);
        check("bp_after_env_unchanged", 32'(env_smooth), 32'hFF);

        // Envelope toggling during the multiply does not disturb the product.
        @(negedge clk);
        envelope_in = 8'hFC;
        in_data     = 8'h7F;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            envelope_in = 8'($urandom);
            @(posedge clk);
            #1 lat++;
        end
        check("envchg_latency", 32'(lat), 32'd9);
        check("envchg_out", 32'(out_data), 32'h7D);
        check("envchg_env_at_accept", 32'(env_smooth), 32'hFC);
        repeat (4) begin
            @(negedge clk);
            envelope_in = 8'($urandom);
        end
        check("envchg_env_held", 32'(env_smooth), 32'hFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
